// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding a single registered binary<->Gray converter.
// Define GRAY_ARB_CNT_EN to add the 16-bit completed-response counter port rsp_count.
module gray_conv_arbiter #(
    parameter  int WIDTH = 4,
    parameter  int N_REQ = 4,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_mode,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_mode
`ifdef GRAY_ARB_CNT_EN
    ,
    output logic [15:0]            rsp_count
`endif
);

    logic                 rsp_valid_r;
    logic [WIDTH-1:0]     rsp_data_r;
    logic [ID_W-1:0]      rsp_id_r;
    logic                 rsp_mode_r;
    logic [ID_W-1:0]      rr_ptr_r;

    logic                 slot_free_s;
    logic [N_REQ-1:0]     grant_s;
    logic [N_REQ-1:0]     ready_s;
    logic [ID_W-1:0]      grant_id_s;
    logic [WIDTH-1:0]     sel_data_s;
    logic                 sel_mode_s;
    logic [WIDTH-1:0]     conv_s;
    logic                 req_xfer_s;
    logic                 rsp_xfer_s;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] d);
        return d ^ {1'b0, d[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int k = WIDTH - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // Upward search from ptr (mod N_REQ) for the first valid requester.
    function automatic logic [N_REQ-1:0] rr_grant(input logic [N_REQ-1:0] valid,
                                                  input logic [ID_W-1:0]  ptr);
        logic [N_REQ-1:0] g;
        logic             hit;
        int               idx;
        g   = {N_REQ{1'b0}};
        hit = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end else begin
                idx = idx;
            end
            if (!hit && valid[idx]) begin
                g[idx] = 1'b1;
                hit    = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return g;
    endfunction

    assign slot_free_s = !rsp_valid_r || rsp_ready;
    assign grant_s     = rr_grant(req_valid, rr_ptr_r);
    assign rsp_xfer_s  = rsp_valid_r && rsp_ready;

    // Grant is only offered when the result register can take a new value.
    always_comb begin
        ready_s = {N_REQ{1'b0}};
        if (slot_free_s) begin
            ready_s = grant_s;
        end else begin
            ready_s = {N_REQ{1'b0}};
        end
    end

    // One-hot grant to requester index.
    always_comb begin
        grant_id_s = {ID_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_s[i]) begin
                grant_id_s = ID_W'(i);
            end else begin
                grant_id_s = grant_id_s;
            end
        end
    end

    // Select the granted operand and convert it in the requested direction.
    always_comb begin
        sel_data_s = req_data[grant_id_s*WIDTH +: WIDTH];
        sel_mode_s = req_mode[grant_id_s];
        if (sel_mode_s) begin
            conv_s = gray2bin(sel_data_s);
        end else begin
            conv_s = bin2gray(sel_data_s);
        end
    end

    assign req_xfer_s = |ready_s;
    assign req_ready  = ready_s;

    // Result register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {WIDTH{1'b0}};
            rsp_id_r    <= {ID_W{1'b0}};
            rsp_mode_r  <= 1'b0;
            rr_ptr_r    <= {ID_W{1'b0}};
        end else if (req_xfer_s) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= conv_s;
            rsp_id_r    <= grant_id_s;
            rsp_mode_r  <= sel_mode_s;
            rr_ptr_r    <= (grant_id_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}}
                                                            : grant_id_s + ID_W'(32'd1);
        end else if (rsp_xfer_s) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_mode  = rsp_mode_r;

`ifdef GRAY_ARB_CNT_EN
    logic [15:0] rsp_count_r;

    // Completed-response counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_count_r <= 16'd0;
        end else if (rsp_xfer_s) begin
            rsp_count_r <= rsp_count_r + 16'd1;
        end else begin
            rsp_count_r <= rsp_count_r;
        end
    end

    assign rsp_count = rsp_count_r;
`endif

endmodule
